// File: rtl/adc_frame_packer_pkg.sv
// adc_pkg: shared constants and frame helpers for the ADC frame packer.
//  CH_W       : channel sample width (signed two's complement)
//  NCH        : channels per scan
//  OFFSET_DEF : default mid-scale code removed from raw samples
//  FRAME_W    : packed frame width, channel k at bits [k*CH_W +: CH_W]
package adc_pkg;
  localparam int CH_W       = 11;
  localparam int NCH        = 4;
  localparam int OFFSET_DEF = 512;
  localparam int FRAME_W    = NCH * CH_W;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [CH_W-1:0] c0, c1, c2, c3
  );
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [CH_W-1:0] unpack_ch(
    input logic [FRAME_W-1:0] f,
    input int                 k
  );
    return f[k*CH_W +: CH_W];
  endfunction
endpackage

// File: rtl/adc_frame_packer_frame_fifo.sv
// frame_fifo: synchronous FIFO with show-ahead read.
//  clk, rst_n : clock, async active-low reset
//  push/wdata : write request; accepted when not full, or when full with a pop
//  pop        : read request; ignored when empty
//  rdata      : head entry (zero while empty)
//  full/empty : occupancy flags
//  level      : entries currently stored (0..2^AW)
module frame_fifo #(
  parameter int W  = 44,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  // No bypass: a write into an empty FIFO shows up the following cycle.
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: snapshots each completed 4-channel ADC scan, removes the
// mid-scale offset, averages 2^LOG2_DECIM scans and queues the result.
//  clk_clk, reset_n     : clock, async active-low reset
//  enable               : accept scans; low drops scans and clears averaging
//  select_ch            : upstream channel pointer, a 3->0 step marks a scan
//  ch0_in..ch3_in       : raw channel codes
//  src_data/valid/ready : show-ahead frame output {ch3,ch2,ch1,ch0}
//  fill_level           : frames buffered
//  overflow, clear_ovf  : sticky drop flag and its clear (set wins)
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int OFFSET     = OFFSET_DEF,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         select_ch,
  input  logic [CH_W-1:0]    ch0_in,
  input  logic [CH_W-1:0]    ch1_in,
  input  logic [CH_W-1:0]    ch2_in,
  input  logic [CH_W-1:0]    ch3_in,
  output logic [FRAME_W-1:0] src_data,
  output logic               src_valid,
  input  logic               src_ready,
  output logic [FIFO_AW:0]   fill_level,
  output logic               overflow,
  input  logic               clear_ovf
);
  localparam int STAGES = 2;
  localparam int ACC_W  = CH_W + LOG2_DECIM;
  localparam int CNT_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int DECIM  = 1 << LOG2_DECIM;

  // vld_pipe[0]: raw snapshot held, [1]: offset-removed sample held,
  // [2]: averaged frame ready to push.
  logic [STAGES:0]    vld_pipe;
  logic [1:0]         sel_q;
  logic               primed, tick, take, last;
  logic [FRAME_W-1:0] raw_in, raw_r, res_frame;
  logic [CNT_W-1:0]   cnt;
  logic               fifo_full, fifo_empty;

  assign raw_in = pack_frame(ch0_in, ch1_in, ch2_in, ch3_in);
  assign tick   = enable & (sel_q == 2'd3) & (select_ch == 2'd0);
  // The first scan after reset or enable rise carries stale upstream data.
  assign take   = tick & primed;
  assign last   = (cnt == CNT_W'(DECIM - 1));

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= '0;
      primed   <= 1'b0;
      vld_pipe <= '0;
      raw_r    <= '0;
      cnt      <= '0;
    end else begin
      sel_q <= select_ch;
      if (!enable)   primed <= 1'b0;
      else if (tick) primed <= 1'b1;
      if (take) raw_r <= raw_in;
      // Dropping enable kills samples not yet folded into a finished frame.
      vld_pipe[0] <= take;
      vld_pipe[1] <= vld_pipe[0] & enable;
      vld_pipe[2] <= vld_pipe[1] & enable & last;
      if (!enable)          cnt <= '0;
      else if (vld_pipe[1]) cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CH_W-1:0]         s_r, res_r;
    logic signed [CH_W-1:0]  s_sgn;
    logic signed [ACC_W-1:0] acc, sum;

    // Upstream codes are 0..1023, so the subtraction never wraps.
    assign s_sgn = s_r;
    assign sum   = acc + ACC_W'(s_sgn);

    always_ff @(posedge clk_clk or negedge reset_n) begin
      if (!reset_n) begin
        s_r   <= '0;
        acc   <= '0;
        res_r <= '0;
      end else begin
        if (vld_pipe[0]) s_r <= unpack_ch(raw_r, k) - CH_W'(OFFSET);
        if (!enable) acc <= '0;
        else if (vld_pipe[1]) begin
          acc <= last ? '0 : sum;
          // Arithmetic shift gives floor rounding for negative averages.
          if (last) res_r <= CH_W'(sum >>> LOG2_DECIM);
        end
      end
    end

    assign res_frame[k*CH_W +: CH_W] = res_r;
  end

  frame_fifo #(
    .W  (FRAME_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk_clk),
    .rst_n (reset_n),
    .push  (vld_pipe[2]),
    .wdata (res_frame),
    .pop   (src_ready),
    .rdata (src_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fill_level)
  );

  assign src_valid = ~fifo_empty;

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n)                               overflow <= 1'b0;
    else if (vld_pipe[2] & fifo_full & ~src_ready) overflow <= 1'b1;
    else if (clear_ovf)                         overflow <= 1'b0;
  end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: two instances (no averaging, 4-frame averaging)
// share scan stimulus; a reference model turns each scan into expected frames
// queued per instance, and monitors pop and compare on every handshake.
module tb_adc_frame_packer;
  logic        clk_clk = 1'b0;
  logic        reset_n, enable, clear_ovf;
  logic [1:0]  select_ch;
  logic [10:0] ch0_in, ch1_in, ch2_in, ch3_in;
  logic [43:0] src_data0, src_data1;
  logic        src_valid0, src_valid1, src_ready0, src_ready1;
  logic [3:0]  fill0, fill1;
  logic        ovf0, ovf1;

  always #5 clk_clk = ~clk_clk;

  adc_frame_packer #(.LOG2_DECIM(0), .FIFO_AW(3)) u0 (
    .clk_clk(clk_clk), .reset_n(reset_n), .enable(enable), .select_ch(select_ch),
    .ch0_in(ch0_in), .ch1_in(ch1_in), .ch2_in(ch2_in), .ch3_in(ch3_in),
    .src_data(src_data0), .src_valid(src_valid0), .src_ready(src_ready0),
    .fill_level(fill0), .overflow(ovf0), .clear_ovf(clear_ovf));

  adc_frame_packer #(.LOG2_DECIM(2), .FIFO_AW(3)) u1 (
    .clk_clk(clk_clk), .reset_n(reset_n), .enable(enable), .select_ch(select_ch),
    .ch0_in(ch0_in), .ch1_in(ch1_in), .ch2_in(ch2_in), .ch3_in(ch3_in),
    .src_data(src_data1), .src_valid(src_valid1), .src_ready(src_ready1),
    .fill_level(fill1), .overflow(ovf1), .clear_ovf(clear_ovf));

  int          total = 0, bad = 0;
  int          chv [4];
  int          dec [2] = '{1, 4};
  bit          primed_m [2];
  int          sum_m [2][4];
  int          n_m [2];
  bit          hold [2];
  bit          exp_ovf [2];
  bit          rnd = 1'b0;
  logic [43:0] q0 [$];
  logic [43:0] q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int r;
    r = a % d;
    if (r < 0) r += d;
    return (a - r) / d;
  endfunction

  function automatic logic [43:0] pack4(input int a, input int b, input int c, input int d);
    logic [43:0] f;
    int v [4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) f[k*11 +: 11] = 11'(v[k]);
    return f;
  endfunction

  // Expected frame: floor of the mean of (code - 512) over the decimation window.
  task automatic push_exp(input int d, input logic [43:0] e);
    if (d == 0) begin
      if (hold[0] && q0.size() >= 8) exp_ovf[0] = 1'b1;
      else q0.push_back(e);
    end else begin
      if (hold[1] && q1.size() >= 8) exp_ovf[1] = 1'b1;
      else q1.push_back(e);
    end
  endtask

  task automatic model_wrap();
    logic [43:0] e;
    int r;
    if (!enable) return;
    for (int d = 0; d < 2; d++) begin
      if (!primed_m[d]) begin
        primed_m[d] = 1'b1;
        continue;
      end
      for (int k = 0; k < 4; k++) sum_m[d][k] += chv[k] - 512;
      n_m[d]++;
      if (n_m[d] == dec[d]) begin
        for (int k = 0; k < 4; k++) begin
          r = fdiv(sum_m[d][k], dec[d]);
          e[k*11 +: 11] = r[10:0];
          sum_m[d][k] = 0;
        end
        n_m[d] = 0;
        push_exp(d, e);
      end
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge clk_clk);
    enable = v;
    if (!v) begin
      for (int d = 0; d < 2; d++) begin
        primed_m[d] = 1'b0;
        n_m[d] = 0;
        for (int k = 0; k < 4; k++) sum_m[d][k] = 0;
      end
    end
  endtask

  task automatic set_chv(input int a, input int b, input int c, input int d);
    chv = '{a, b, c, d};
  endtask

  task automatic rand_chv();
    for (int k = 0; k < 4; k++) chv[k] = int'($urandom_range(0, 1023));
  endtask

  task automatic drive_ch();
    ch0_in = 11'(chv[0]);
    ch1_in = 11'(chv[1]);
    ch2_in = 11'(chv[2]);
    ch3_in = 11'(chv[3]);
  endtask

  task automatic do_wrap(input int gap);
    @(negedge clk_clk);
    select_ch = 2'd3;
    drive_ch();
    @(negedge clk_clk);
    select_ch = 2'd0;
    model_wrap();
    repeat (gap) @(negedge clk_clk);
  endtask

  // Wrap, then act in the cycle the frame reaches the FIFO write port:
  // what=1 pulses clear_ovf, what=2 pulses src_ready0.
  task automatic wrap_then(input int what);
    @(negedge clk_clk);
    select_ch = 2'd3;
    drive_ch();
    @(negedge clk_clk);
    select_ch = 2'd0;
    model_wrap();
    repeat (3) @(negedge clk_clk);
    if (what == 1) clear_ovf = 1'b1;
    else src_ready0 = 1'b1;
    @(negedge clk_clk);
    clear_ovf = 1'b0;
    if (what == 2) src_ready0 = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk_clk);
      n++;
    end
    repeat (2) @(negedge clk_clk);
    check({tag, "_pending0"}, q0.size(), 0);
    check({tag, "_pending1"}, q1.size(), 0);
    check({tag, "_fill0"}, fill0, 0);
    check({tag, "_fill1"}, fill1, 0);
  endtask

  // Scoreboard monitors: compare the head frame on every accepted transfer.
  always begin
    @(negedge clk_clk);
    #1;
    if (src_valid0 && src_ready0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL d0_frame actual=%0h required=none", src_data0);
      end else check("d0_frame", src_data0, q0.pop_front());
    end
    if (src_valid1 && src_ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL d1_frame actual=%0h required=none", src_data1);
      end else check("d1_frame", src_data1, q1.pop_front());
    end
  end

  // Random back-pressure; forced ready near full keeps the FIFOs from dropping.
  always begin
    @(negedge clk_clk);
    if (rnd) begin
      src_ready0 = (fill0 >= 4'd6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      src_ready1 = (fill1 >= 4'd6) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear_ovf = 1'b0; select_ch = 2'd0;
    src_ready0 = 1'b1; src_ready1 = 1'b1;
    set_chv(512, 512, 512, 512);
    drive_ch();

    // 1: reset held while the channel pointer cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_clk);
      select_ch = i[1:0];
      check("rst_valid0", src_valid0, 0);
      check("rst_valid1", src_valid1, 0);
      check("rst_fill0", fill0, 0);
      check("rst_ovf1", ovf1, 0);
      check("rst_data0", src_data0, 0);
    end
    @(negedge clk_clk);
    reset_n = 1'b1;
    select_ch = 2'd0;

    // 2: no averaging, prime then one frame with exact latency
    set_chv(600, 512, 100, 1023);
    do_wrap(3);
    check("prime_no_frame", src_valid0, 0);
    @(negedge clk_clk);
    select_ch = 2'd3;
    @(negedge clk_clk);
    select_ch = 2'd0;
    model_wrap();
    repeat (3) @(negedge clk_clk);
    check("lat_edge2_valid", src_valid0, 0);
    @(negedge clk_clk);
    check("lat_edge3_valid", src_valid0, 1);
    check("lat_data", src_data0, pack4(88, 0, -412, 511));
    repeat (3) @(negedge clk_clk);
    check("one_frame_only", src_valid0, 0);

    // 3: 4-frame average with floor rounding
    repeat (4) @(negedge clk_clk);
    set_en(1'b0);
    set_en(1'b1);
    do_wrap(1);
    for (int i = 0; i < 4; i++) begin
      set_chv(520 + 4 * i, 512, 512, 512);
      do_wrap(i % 3);
    end
    for (int i = 0; i < 4; i++) begin
      set_chv((i == 0) ? 511 : 510, 512, 512, 512);
      do_wrap(0);
    end
    drain("avg");

    // 4: overflow with back-pressure, set beats clear, ordered drain
    src_ready0 = 1'b0;
    hold[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_chv();
      do_wrap(0);
    end
    rand_chv();
    wrap_then(1);
    repeat (3) @(negedge clk_clk);
    check("ovf_fill0", fill0, q0.size());
    check("ovf_fill0_max", fill0, 8);
    check("ovf_set_wins", ovf0, exp_ovf[0]);
    check("ovf_other_inst", ovf1, exp_ovf[1]);
    hold[0] = 1'b0;
    src_ready0 = 1'b1;
    drain("ovf");
    check("ovf_sticky", ovf0, exp_ovf[0]);
    @(negedge clk_clk);
    clear_ovf = 1'b1;
    @(negedge clk_clk);
    clear_ovf = 1'b0;
    exp_ovf[0] = 1'b0;
    check("ovf_cleared", ovf0, exp_ovf[0]);

    // 5: enable drop discards a partial average, rise primes again
    repeat (4) @(negedge clk_clk);
    set_en(1'b0);
    set_en(1'b1);
    do_wrap(1);
    for (int i = 0; i < 2; i++) begin
      rand_chv();
      do_wrap(1);
    end
    repeat (4) @(negedge clk_clk);
    set_en(1'b0);
    for (int i = 0; i < 2; i++) begin
      rand_chv();
      do_wrap(1);
    end
    set_en(1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_chv();
      do_wrap(i % 2);
    end
    drain("en");

    // 6: pointer steps without a 3->0 wrap
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_clk);
      select_ch = (i < 4) ? i[1:0] : ((i == 4) ? 2'd2 : 2'd3);
    end
    repeat (6) @(negedge clk_clk);
    check("nowrap_valid0", src_valid0, 0);
    check("nowrap_valid1", src_valid1, 0);
    check("nowrap_fill0", fill0, 0);
    // 6: push and pop together while full
    src_ready0 = 1'b0;
    hold[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_chv();
      do_wrap(1);
    end
    repeat (4) @(negedge clk_clk);
    check("full_fill0", fill0, 8);
    hold[0] = 1'b0;
    rand_chv();
    wrap_then(2);
    check("pushpop_fill0", fill0, q0.size());
    check("pushpop_fill0_8", fill0, 8);
    check("pushpop_no_ovf", ovf0, 0);
    src_ready0 = 1'b1;
    drain("full");

    // Randomized scans, spacing, enable toggles and back-pressure
    rnd = 1'b1;
    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat (4) @(negedge clk_clk);
        set_en(1'b0);
        rand_chv();
        do_wrap(int'($urandom_range(0, 3)));
        set_en(1'b1);
      end else begin
        rand_chv();
        do_wrap(int'($urandom_range(0, 4)));
      end
    end
    rnd = 1'b0;
    @(negedge clk_clk);
    src_ready0 = 1'b1;
    src_ready1 = 1'b1;
    drain("rand");
    check("rand_ovf0", ovf0, 0);
    check("rand_ovf1", ovf1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
